demux_pack_param: RTL and testbench

- Parametrised successor of the fixed 8->32 demux: packs RATIO consecutive IN_W-bit beats into one IN_W*RATIO-bit word, first beat in the MSBs.
- Sits between serial_paralelo and the lane/word logic of the PCI physical layer.
- New versus the fixed block: a single clock, gap tolerance (valid_in may drop mid-word), start-of-word realignment with a drop counter, and a DEPTH-entry output FIFO with ready/valid backpressure.

---
 rtl/pci_phy_pkg.sv | 27 ++
 rtl/sync_fifo_param.sv | 71 +++++++
 rtl/demux_pack_param.sv | 118 +++++++++++
 tb/tb_demux_pack_param.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_phy_pkg.sv
// Shared constants, types and helpers for the PCI physical-layer datapath blocks.
// Holds parameter defaults and the width helper used for pointers and counters.
package pci_phy_pkg;

   localparam int IN_W_DEF  = 8;
   localparam int RATIO_DEF = 4;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 8;

   // What an incoming beat does to the packer on a given cycle.
   typedef enum logic [1:0] {
      BEAT_IDLE,
      BEAT_SHIFT,
      BEAT_REALIGN
   } beat_kind_e;

   // Number of bits needed to index 'value' distinct items.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with occupancy count and empty/full flags.
// Output is the registered head entry; there is no write-to-read bypass.
module sync_fifo_param
   import pci_phy_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEPTH_DEF,
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk_4f,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (push) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_wrPtr <= nextPtr(r_wrPtr);
         end
         if (pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rdPtr];
   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/demux_pack_param.sv
// Packs RATIO consecutive IN_W-bit beats into one word (first beat in the MSBs),
// with gap tolerance, start-of-word realignment, a drop counter and an output FIFO.
module demux_pack_param
   import pci_phy_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int RATIO = RATIO_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk_4f,
   input  logic                  reset,
   input  logic [IN_W-1:0]       data_in,
   input  logic                  valid_in,
   input  logic                  sow_in,
   output logic                  ready_in,
   output logic [IN_W*RATIO-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic                  align_err,
   output logic [CNT_W-1:0]      drop_count
);

   localparam int W       = IN_W * RATIO;
   localparam int ACC_W   = (RATIO > 1) ? (RATIO - 1) * IN_W : 1;
   localparam int BEAT_CW = clog2(RATIO + 1);
   localparam int FIFO_CW = clog2(DEPTH + 1);

   logic [ACC_W-1:0]   r_acc;
   logic [BEAT_CW-1:0] r_cnt;
   logic               r_alignErr;
   logic [CNT_W-1:0]   r_dropCount;

   logic               w_accept;
   logic               w_complete;
   logic               w_pop;
   logic               w_empty;
   logic               w_full;
   logic [FIFO_CW-1:0] w_fifoCount;
   logic [W-1:0]       w_shifted;
   logic [W-1:0]       w_word;
   logic [ACC_W-1:0]   w_accLoad;
   logic [BEAT_CW-1:0] w_effCnt;
   beat_kind_e         w_kind;

   assign ready_in = (w_fifoCount < FIFO_CW'(DEPTH));
   assign w_accept = valid_in && ready_in;
   assign w_pop    = valid_out && ready_out;

   // Only the oldest RATIO-1 beats are kept; the incoming beat completes the word.
   if (RATIO > 1) begin : g_multi
      assign w_shifted = {r_acc, data_in};
      assign w_accLoad = (w_kind == BEAT_REALIGN) ? ACC_W'(data_in) : w_shifted[ACC_W-1:0];
   end else begin : g_single
      assign w_shifted = data_in;
      assign w_accLoad = '0;
   end

   always_comb begin
      w_kind   = BEAT_IDLE;
      w_effCnt = r_cnt;
      w_word   = w_shifted;
      if (w_accept) begin
         if (sow_in && (r_cnt != '0)) begin
            w_kind   = BEAT_REALIGN;
            w_effCnt = BEAT_CW'(1);
            w_word   = W'(data_in);
         end else begin
            w_kind   = BEAT_SHIFT;
            w_effCnt = r_cnt + BEAT_CW'(1);
         end
      end
      w_complete = w_accept && (w_effCnt == BEAT_CW'(RATIO));
   end

   // Beat count holds across idle cycles, so gaps of any length are tolerated.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_accLoad;
         r_cnt <= w_complete ? '0 : w_effCnt;
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_alignErr  <= 1'b0;
         r_dropCount <= '0;
      end else begin
         r_alignErr <= (w_kind == BEAT_REALIGN);
         if ((w_kind == BEAT_REALIGN) && (r_dropCount != {CNT_W{1'b1}})) begin
            r_dropCount <= r_dropCount + CNT_W'(1);
         end
      end
   end

   sync_fifo_param #(
      .WIDTH(W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_4f(clk_4f),
      .reset (reset),
      .push  (w_complete && !w_full),
      .pop   (w_pop),
      .din   (w_word),
      .dout  (data_out),
      .count (w_fifoCount),
      .empty (w_empty),
      .full  (w_full)
   );

   assign valid_out  = !w_empty;
   assign align_err  = r_alignErr;
   assign drop_count = r_dropCount;

endmodule

// File: tb/tb_demux_pack_param.sv
// Scoreboard bench for demux_pack_param: a queue-based model predicts words,
// a separate monitor pops and compares whenever the DUT hands a word downstream.
module tb_demux_pack_param;

   localparam int IN_W  = 8;
   localparam int RATIO = 4;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
   localparam int W     = IN_W * RATIO;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic            clk_4f;
   logic            reset;
   logic [IN_W-1:0] data_in;
   logic            valid_in;
   logic            sow_in;
   logic            ready_in;
   logic [W-1:0]    data_out;
   logic            valid_out;
   logic            ready_out;
   logic            align_err;
   logic [CNT_W-1:0] drop_count;

   logic [IN_W-1:0]  s_dataIn;
   logic             s_validIn;
   logic             s_sowIn;
   logic             s_readyIn;
   logic [IN_W-1:0]  s_dataOut;
   logic             s_validOut;
   logic             s_readyOut;
   logic             s_alignErr;
   logic [CNT_W-1:0] s_dropCount;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]    expQ[$];
   logic [IN_W-1:0] part[$];
   int              occ = 0;
   int              expDrops = 0;
   bit              expAlign = 0;

   demux_pack_param #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .sow_in(sow_in), .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
      .ready_out(ready_out), .align_err(align_err), .drop_count(drop_count)
   );

   demux_pack_param #(.IN_W(IN_W), .RATIO(1), .DEPTH(DEPTH), .CNT_W(CNT_W)) dutSingle (
      .clk_4f(clk_4f), .reset(reset), .data_in(s_dataIn), .valid_in(s_validIn),
      .sow_in(s_sowIn), .ready_in(s_readyIn), .data_out(s_dataOut), .valid_out(s_validOut),
      .ready_out(s_readyOut), .align_err(s_alignErr), .drop_count(s_dropCount)
   );

   initial clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Reference packer: a beat list per word, completed words go to the scoreboard.
   task automatic modelBeat(input logic [IN_W-1:0] d, input bit sow, output bit pushed);
      logic [W-1:0] word;
      pushed = 0;
      if (sow && part.size() != 0) begin
         part.delete();
         expAlign = 1;
         if (expDrops < SAT) expDrops++;
      end
      part.push_back(d);
      if (part.size() == RATIO) begin
         word = '0;
         foreach (part[i]) word = (word << IN_W) | W'(part[i]);
         expQ.push_back(word);
         part.delete();
         pushed = 1;
      end
   endtask

   // One clock of stimulus; model advances on the edge, flags checked just after.
   task automatic applyStimulus(input bit v, input logic [IN_W-1:0] d, input bit s,
                                input bit ro, output bit acc);
      bit pop;
      bit pushed;
      valid_in  = v;
      data_in   = d;
      sow_in    = s;
      ready_out = ro;
      @(negedge clk_4f);
      checkOutput("ready_in", ready_in, occ < DEPTH);
      acc = v && (occ < DEPTH);
      pop = (occ > 0) && ro;
      @(posedge clk_4f);
      expAlign = 0;
      pushed   = 0;
      if (acc) modelBeat(d, s, pushed);
      occ = occ + int'(pushed) - int'(pop);
      #1;
      checkOutput("align_err", align_err, expAlign);
      checkOutput("drop_count", drop_count, expDrops);
   endtask

   task automatic sendBeat(input logic [IN_W-1:0] d, input bit s, input bit ro);
      bit acc;
      int tries;
      tries = 0;
      do begin
         applyStimulus(1'b1, d, s, ro, acc);
         tries++;
      end while (!acc && tries < 64);
      checkOutput("accept_timeout", acc, 1);
   endtask

   task automatic idle(input int n, input bit ro);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, ro, acc);
   endtask

   task automatic sendWord(input logic [W-1:0] word, input bit ro);
      logic [W-1:0] tmp;
      tmp = word;
      for (int i = 0; i < RATIO; i++) begin
         sendBeat(tmp[W-1 -: IN_W], i == 0, ro);
         tmp = tmp << IN_W;
      end
   endtask

   // Monitor: every downstream transfer must match the oldest predicted word.
   initial begin
      logic [W-1:0] expWord;
      forever begin
         @(negedge clk_4f);
         if (!reset) begin
            checkOutput("valid_out", valid_out, occ > 0);
            if (valid_out && ready_out) begin
               checkOutput("word_expected", expQ.size() != 0, 1);
               if (expQ.size() != 0) begin
                  expWord = expQ.pop_front();
                  checkOutput("data_out", data_out, expWord);
               end
            end
         end
      end
   end

   initial begin
      bit acc;
      bit havePend;
      bit pendSow;
      logic [IN_W-1:0] pendData;
      logic [IN_W-1:0] sbeat;

      reset = 1'b1; valid_in = 0; data_in = '0; sow_in = 0; ready_out = 0;
      s_validIn = 0; s_dataIn = '0; s_sowIn = 0; s_readyOut = 1;
      #1;
      checkOutput("rst_data_out", data_out, 0);
      checkOutput("rst_valid_out", valid_out, 0);
      checkOutput("rst_align_err", align_err, 0);
      checkOutput("rst_drop_count", drop_count, 0);
      checkOutput("rst_ready_in", ready_in, 1);
      @(posedge clk_4f); @(posedge clk_4f); #1;
      reset = 1'b0;

      // Back-to-back word
      sendBeat(8'hAA, 1, 1); sendBeat(8'hBB, 0, 1); sendBeat(8'hCC, 0, 1); sendBeat(8'hDD, 0, 1);
      checkOutput("b2b_valid", valid_out, 1);
      checkOutput("b2b_data", data_out, 32'hAABBCCDD);
      idle(1, 1);
      checkOutput("b2b_single", valid_out, 0);

      // Gap mid-word
      sendBeat(8'hAA, 1, 1); sendBeat(8'hBB, 0, 1);
      idle(3, 1);
      sendBeat(8'hCC, 0, 1); sendBeat(8'hDD, 0, 1);
      checkOutput("gap_data", data_out, 32'hAABBCCDD);
      idle(2, 1);

      // Realignment
      sendBeat(8'h11, 1, 1); sendBeat(8'h22, 0, 1); sendBeat(8'h33, 1, 1);
      checkOutput("realign_pulse", align_err, 1);
      checkOutput("realign_drop", drop_count, 1);
      sendBeat(8'h44, 0, 1); sendBeat(8'h55, 0, 1); sendBeat(8'h66, 0, 1);
      checkOutput("realign_data", data_out, 32'h33445566);
      idle(2, 1);

      // Backpressure: two words fill the FIFO, third stalls until drained
      sendWord(32'h01020304, 0);
      sendWord(32'h05060708, 0);
      checkOutput("full_ready_in", ready_in, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h09, 1'b1, 1'b0, acc);
      sendWord(32'h090A0B0C, 1);
      idle(6, 1);

      // Simultaneous push and pop with one word held
      sendWord(32'hA1A2A3A4, 0);
      sendBeat(8'hB1, 1, 0); sendBeat(8'hB2, 0, 0); sendBeat(8'hB3, 0, 0); sendBeat(8'hB4, 0, 1);
      checkOutput("simul_valid", valid_out, 1);
      checkOutput("simul_ready_in", ready_in, 1);
      checkOutput("simul_data", data_out, 32'hB1B2B3B4);
      idle(3, 1);

      // Reset mid-word
      sendBeat(8'hE1, 1, 1); sendBeat(8'hE2, 0, 1);
      sendBeat(8'hE3, 1, 1);
      reset = 1'b1;
      part.delete(); expQ.delete(); occ = 0; expDrops = 0; expAlign = 0;
      #1;
      checkOutput("midrst_data_out", data_out, 0);
      checkOutput("midrst_valid_out", valid_out, 0);
      checkOutput("midrst_align_err", align_err, 0);
      checkOutput("midrst_drop_count", drop_count, 0);
      checkOutput("midrst_ready_in", ready_in, 1);
      #2;
      reset = 1'b0;
      sendBeat(8'hC1, 0, 1); sendBeat(8'hC2, 0, 1); sendBeat(8'hC3, 0, 1); sendBeat(8'hC4, 0, 1);
      checkOutput("postrst_data", data_out, 32'hC1C2C3C4);
      checkOutput("postrst_drop", drop_count, 0);
      idle(3, 1);

      // Single-beat words on the RATIO=1 instance
      for (int k = 0; k < 8; k++) begin
         sbeat      = 8'($urandom);
         s_dataIn   = sbeat;
         s_validIn  = 1'b1;
         s_sowIn    = 1'($urandom);
         @(posedge clk_4f); #1;
         checkOutput("r1_valid", s_validOut, 1);
         checkOutput("r1_data", s_dataOut, sbeat);
         checkOutput("r1_ready_in", s_readyIn, 1);
         checkOutput("r1_align_err", s_alignErr, 0);
      end
      s_validIn = 1'b0;
      @(posedge clk_4f); #1;
      checkOutput("r1_drained", s_validOut, 0);
      checkOutput("r1_drop", s_dropCount, 0);

      // Randomised traffic; an offered beat is held until accepted
      havePend = 0; pendData = '0; pendSow = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!havePend && $urandom_range(0, 3) != 0) begin
            havePend = 1;
            pendData = 8'($urandom);
            pendSow  = ($urandom_range(0, 5) == 0);
         end
         applyStimulus(havePend, pendData, pendSow, $urandom_range(0, 2) != 0, acc);
         if (acc) havePend = 0;
      end
      idle(4, 1);

      // Drop counter saturation
      sendBeat(8'h5A, 1, 1);
      for (int i = 0; i < 300; i++) sendBeat(8'(i), 1, 1);
      checkOutput("drop_sat", drop_count, SAT);
      sendBeat(8'h71, 0, 1); sendBeat(8'h72, 0, 1); sendBeat(8'h73, 0, 1);
      idle(4, 1);
      checkOutput("queue_empty", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
